// File: rtl/b200_pkg.sv
// Shared types and default timing for the B200 reset sequencer.
package b200_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLDOFF   = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_NUM_STAGES     = 3;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 16;
  localparam int unsigned DEF_STAGE_GAP      = 8;
  localparam int unsigned DEF_LOCK_FILT      = 4;
  localparam int unsigned DEF_LOSS_CNT_W     = 8;

endpackage

// File: rtl/b200_lock_filter.sv
// Brings the asynchronous PLL lock into bus_clk and accepts it only after
// LOCK_FILT consecutive synchronised-high samples; any low drops it at once.
module b200_lock_filter
  import b200_pkg::*;
#(
  parameter int unsigned LOCK_FILT = DEF_LOCK_FILT
) (
  input  logic bus_clk,
  input  logic reset_global,
  input  logic pll_locked_i,
  output logic locked_f_o
);

  localparam int unsigned CNT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             locked_q;

  // Two-flop synchroniser followed by the consecutive-high qualifier.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked_i;
      sync2_q <= sync1_q;
      if (!sync2_q) begin
        cnt_q    <= '0;
        locked_q <= 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        locked_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign locked_f_o = locked_q;

endmodule

// File: rtl/b200_reset_sequencer.sv
// Ordered multi-domain reset release: waits for filtered PLL lock, holds off,
// then releases stage 0..NUM_STAGES-1 with a fixed gap. Re-sequences on lock
// loss or software request and keeps a saturating lock-loss count.
module b200_reset_sequencer
  import b200_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP,
  parameter int unsigned LOCK_FILT      = DEF_LOCK_FILT,
  parameter int unsigned LOSS_CNT_W     = DEF_LOSS_CNT_W
) (
  input  logic                  bus_clk,
  input  logic                  reset_global,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  input  logic                  clear_loss,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  clocks_ready,
  output logic                  seq_busy,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int unsigned IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  logic                  locked_f;
  logic                  lock_lost;
  seq_state_e            state_q;
  logic [HOLD_W-1:0]     hold_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_next;
  logic [NUM_STAGES-1:0] stage_rst_q;
  logic                  ready_q;
  logic                  busy_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_d;

  b200_lock_filter #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filter (
    .bus_clk      (bus_clk),
    .reset_global (reset_global),
    .pll_locked_i (pll_locked),
    .locked_f_o   (locked_f)
  );

  // Lock is only "lost" once it had been accepted, i.e. outside WAIT_LOCK.
  assign lock_lost = !locked_f && (state_q != ST_WAIT_LOCK);
  assign idx_next  = idx_q + 1'b1;

  // Sequencer FSM with registered stage resets, ready and busy flags.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      state_q     <= ST_WAIT_LOCK;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else if (lock_lost) begin
      // Lock loss overrides any software request in the same cycle.
      state_q     <= ST_WAIT_LOCK;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (locked_f) begin
            state_q    <= ST_HOLDOFF;
            hold_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (sw_reset_req) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            stage_rst_q[0] <= 1'b0;
            idx_q          <= '0;
            gap_cnt_q      <= '0;
            if (NUM_STAGES == 1) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_RELEASE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (sw_reset_req) begin
            state_q     <= ST_HOLDOFF;
            hold_cnt_q  <= '0;
            stage_rst_q <= '1;
          end else if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q             <= '0;
            stage_rst_q[idx_next] <= 1'b0;
            idx_q                 <= idx_next;
            if (idx_next == IDX_LAST) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (sw_reset_req) begin
            state_q     <= ST_HOLDOFF;
            hold_cnt_q  <= '0;
            stage_rst_q <= '1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_WAIT_LOCK;
          stage_rst_q <= '1;
          ready_q     <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Saturating lock-loss counter; clear wins over a same-cycle increment.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (clear_loss) begin
      loss_cnt_d = '0;
    end else if (lock_lost && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  // Lock-loss counter register.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign stage_rst       = stage_rst_q;
  assign clocks_ready    = ready_q;
  assign seq_busy        = busy_q;
  assign lock_loss_count = loss_cnt_q;

endmodule
